// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures the high time of each pulse on an asynchronous line,
// converts legal widths back to an 8-bit position code and flags bad pulses or signal loss.
module servo_pwm_decoder #(
   parameter int OFFSET    = 127,
   parameter int MIN_WIDTH = 127,
   parameter int MAX_WIDTH = 382,
   parameter int TIMEOUT   = 3000,
   parameter int CW        = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pwm_in,
   output logic [7:0]    position,
   output logic          valid,
   output logic          pulse_err,
   output logic [CW-1:0] width_raw,
   output logic          signal_lost
);

   typedef enum logic [1:0] {
      ARM       = 2'd0,
      WAIT_RISE = 2'd1,
      HIGH      = 2'd2
   } state_t;

   localparam logic [CW-1:0] WIDTH_SAT = {CW{1'b1}};
   localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT);
   localparam logic [CW-1:0] MIN_W     = CW'(MIN_WIDTH);
   localparam logic [CW-1:0] MAX_W     = CW'(MAX_WIDTH);
   localparam logic [7:0]    OFFSET_8  = 8'(OFFSET);

   state_t        state_q, state_d;
   logic          s1_q, s2_q, s3_q;
   logic [1:0]    fill_q, fill_d;
   logic [CW-1:0] width_cnt_q, width_cnt_d;
   logic [CW-1:0] width_raw_q, width_raw_d;
   logic [CW-1:0] to_cnt_q, to_cnt_d;
   logic          eval_q, eval_d;
   logic [7:0]    position_q, position_d;
   logic          valid_q, valid_d;
   logic          pulse_err_q, pulse_err_d;
   logic          lost_q, lost_d;
   logic          rise_s, fall_s, expire_s, legal_s;

   always_comb begin
      rise_s   = s2_q & ~s3_q;
      fall_s   = ~s2_q & s3_q;
      expire_s = ~rise_s && (to_cnt_q == (TO_LIMIT - {{(CW-1){1'b0}}, 1'b1}));
      legal_s  = (width_raw_q >= MIN_W) && (width_raw_q <= MAX_W);
   end

   // ARM only trusts s2 once the synchroniser holds two real samples after reset,
   // so a pulse already in progress at reset release is never measured.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARM: begin
            if ((fill_q == 2'd2) && !s2_q) state_d = WAIT_RISE;
            else                           state_d = ARM;
         end
         WAIT_RISE: begin
            if (rise_s) state_d = HIGH;
            else        state_d = WAIT_RISE;
         end
         HIGH: begin
            if (expire_s)    state_d = ARM;
            else if (fall_s) state_d = WAIT_RISE;
            else             state_d = HIGH;
         end
         default: state_d = ARM;
      endcase
   end

   always_comb begin
      fill_d      = (fill_q == 2'd2) ? fill_q : (fill_q + 2'd1);
      width_cnt_d = width_cnt_q;
      width_raw_d = width_raw_q;
      eval_d      = 1'b0;
      if (rise_s)                 to_cnt_d = '0;
      else if (to_cnt_q == TO_LIMIT) to_cnt_d = to_cnt_q;
      else                        to_cnt_d = to_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      if ((state_q == WAIT_RISE) && rise_s) begin
         width_cnt_d = {{(CW-1){1'b0}}, 1'b1};
      end else if ((state_q == HIGH) && s2_q && (width_cnt_q != WIDTH_SAT)) begin
         width_cnt_d = width_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         width_cnt_d = width_cnt_q;
      end
      if ((state_q == HIGH) && fall_s && !expire_s) begin
         width_raw_d = width_cnt_q;
         eval_d      = 1'b1;
      end else begin
         width_raw_d = width_raw_q;
         eval_d      = 1'b0;
      end
   end

   always_comb begin
      valid_d     = eval_q && legal_s;
      pulse_err_d = eval_q && !legal_s;
      if (valid_d) position_d = width_raw_q[7:0] - OFFSET_8;
      else         position_d = position_q;
      if (expire_s)     lost_d = 1'b1;
      else if (valid_d) lost_d = 1'b0;
      else              lost_d = lost_q;
   end

   // Single register bank for synchroniser, FSM, counters and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         fill_q      <= 2'd0;
         state_q     <= ARM;
         width_cnt_q <= '0;
         width_raw_q <= '0;
         to_cnt_q    <= '0;
         eval_q      <= 1'b0;
         position_q  <= 8'd0;
         valid_q     <= 1'b0;
         pulse_err_q <= 1'b0;
         lost_q      <= 1'b1;
      end else begin
         s1_q        <= pwm_in;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         fill_q      <= fill_d;
         state_q     <= state_d;
         width_cnt_q <= width_cnt_d;
         width_raw_q <= width_raw_d;
         to_cnt_q    <= to_cnt_d;
         eval_q      <= eval_d;
         position_q  <= position_d;
         valid_q     <= valid_d;
         pulse_err_q <= pulse_err_d;
         lost_q      <= lost_d;
      end
   end

   assign position    = position_q;
   assign valid       = valid_q;
   assign pulse_err   = pulse_err_q;
   assign width_raw   = width_raw_q;
   assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder: directed scenarios plus random pulse trains,
// expectations derived per pulse from width, legal range and timeout rules.
module tb_servo_pwm_decoder;

   localparam int CW      = 15;
   localparam int OFFSET  = 127;
   localparam int MIN_W   = 127;
   localparam int MAX_W   = 382;
   localparam int TIMEOUT = 3000;

   logic          clk = 1'b0;
   logic          rst;
   logic          pwm_in;
   logic [7:0]    position;
   logic          valid;
   logic          pulse_err;
   logic [CW-1:0] width_raw;
   logic          signal_lost;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int n_err    = 0;
   int exp_pos  = 0;
   int exp_lost = 1;
   int last_rise_cyc = 0;

   servo_pwm_decoder #(
      .OFFSET(OFFSET), .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W), .TIMEOUT(TIMEOUT), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in), .position(position), .valid(valid),
      .pulse_err(pulse_err), .width_raw(width_raw), .signal_lost(signal_lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid)     n_valid <= n_valid + 1;
      if (pulse_err) n_err   <= n_err + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives w high ticks then low; checks the strobe four edges after the fall.
   task automatic send_pulse(input int w, input int gap);
      int  v0, e0;
      bit  legal;
      legal = (w >= MIN_W) && (w <= MAX_W);
      check_eq("lost_before", {31'd0, signal_lost}, exp_lost);
      v0 = n_valid;
      e0 = n_err;
      pwm_in = 1'b1;
      last_rise_cyc = cyc;
      repeat (w) step();
      pwm_in = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      if (legal) begin
         exp_pos  = w - OFFSET;
         exp_lost = 0;
      end
      check_eq("valid", {31'd0, valid}, {31'd0, legal});
      check_eq("pulse_err", {31'd0, pulse_err}, {31'd0, !legal});
      check_eq("position", {24'd0, position}, exp_pos);
      check_eq("width_raw", {17'd0, width_raw}, w);
      check_eq("signal_lost", {31'd0, signal_lost}, exp_lost);
      repeat (gap) step();
      check_eq("valid_count", n_valid - v0, {31'd0, legal});
      check_eq("err_count", n_err - e0, {31'd0, !legal});
   endtask

   initial begin
      int v0, e0, w, r;
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) step();
      check_eq("rst_position", {24'd0, position}, 0);
      check_eq("rst_valid", {31'd0, valid}, 0);
      check_eq("rst_pulse_err", {31'd0, pulse_err}, 0);
      check_eq("rst_width_raw", {17'd0, width_raw}, 0);
      check_eq("rst_lost", {31'd0, signal_lost}, 1);
      rst = 1'b0;
      repeat (5) step();

      repeat (3) send_pulse(127, 2371);
      send_pulse(327, 100);
      send_pulse(382, 100);
      send_pulse(126, 100);
      send_pulse(383, 100);
      check_eq("pos_held", {24'd0, position}, 255);
      send_pulse(327, 100);
      send_pulse(126, 100);
      send_pulse(383, 100);
      check_eq("pos_held_200", {24'd0, position}, 200);

      // Loss of signal: line held low after a legal pulse.
      send_pulse(200, 10);
      while (cyc < last_rise_cyc + TIMEOUT + 2) @(negedge clk);
      check_eq("lost_pre_expiry", {31'd0, signal_lost}, 0);
      @(posedge clk);
      @(negedge clk);
      check_eq("lost_at_expiry", {31'd0, signal_lost}, 1);
      exp_lost = 1;
      repeat (20) step();
      send_pulse(227, 100);

      // Line high across reset release: partial pulse must be ignored.
      v0 = n_valid;
      e0 = n_err;
      pwm_in = 1'b1;
      rst    = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (150) step();
      pwm_in = 1'b0;
      repeat (20) step();
      check_eq("partial_valid", n_valid - v0, 0);
      check_eq("partial_err", n_err - e0, 0);
      check_eq("partial_pos", {24'd0, position}, 0);
      exp_pos  = 0;
      exp_lost = 1;
      send_pulse(227, 50);

      // Stuck high.
      v0 = n_valid;
      e0 = n_err;
      pwm_in = 1'b1;
      repeat (4000) step();
      check_eq("stuck_lost", {31'd0, signal_lost}, 1);
      pwm_in = 1'b0;
      repeat (20) step();
      check_eq("stuck_valid", n_valid - v0, 0);
      check_eq("stuck_err", n_err - e0, 0);
      exp_lost = 1;
      send_pulse(227, 50);

      // Random pulse trains, occasional short glitches.
      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) w = $urandom_range(1, 20);
         else        w = $urandom_range(100, 420);
         send_pulse(w, $urandom_range(6, 200));
      end

      // Reset asserted mid-pulse.
      send_pulse(300, 20);
      pwm_in = 1'b1;
      repeat (50) step();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("midrst_position", {24'd0, position}, 0);
      check_eq("midrst_valid", {31'd0, valid}, 0);
      check_eq("midrst_pulse_err", {31'd0, pulse_err}, 0);
      check_eq("midrst_width_raw", {17'd0, width_raw}, 0);
      check_eq("midrst_lost", {31'd0, signal_lost}, 1);
      #1;
      rst = 1'b0;
      repeat (30) step();
      pwm_in = 1'b0;
      repeat (10) step();
      exp_pos  = 0;
      exp_lost = 1;
      send_pulse(300, 30);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
Receive-side counterpart of the servo PWM driver. Samples one servo PWM line and measures the high time of each pulse in clk ticks. Converts that width back to the 8-bit position code (position = width − OFFSET) and flags malformed pulses or loss of signal. Used as a loopback checker on driver outputs and for reading external PWM sources. Runs on the same PWM tick clock as the driver (2500 ticks = 20 ms).

Parameters:
OFFSET, 127, ticks of high time corresponding to position 0 (driver emits width = position + 127)
MIN_WIDTH, 127, smallest legal pulse width in ticks
MAX_WIDTH, 382, largest legal pulse width in ticks (OFFSET + 255)
TIMEOUT, 3000, ticks without a rising edge, or of continuous high, before signal_lost asserts
CW, 15, width of internal width and timeout counters

Ports:
clk  input  1  PWM tick clock; all logic on posedge
rst  input  1  synchronous reset, active-high
pwm_in  input  1  asynchronous servo PWM line
position  output  8  last successfully decoded position code
valid  output  1  one-cycle strobe: position just updated
pulse_err  output  1  one-cycle strobe: last pulse width outside [MIN_WIDTH, MAX_WIDTH]
width_raw  output  CW  last measured width in ticks, legal or not
signal_lost  output  1  level: no usable pulse train

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high.
- Synchroniser: pwm_in passes through 2 FFs (s1, s2). s3 holds the previous s2.
- Edge detection: rise = s2 & ~s3; fall = ~s2 & s3.
- Reset values:
  - position = 0, valid = 0, pulse_err = 0, width_raw = 0
  - signal_lost = 1
  - sync FFs = 0, counters = 0, state = ARM
- ARM: wait for s2 = 0, then go to WAIT_RISE. This prevents measuring a partial pulse after reset.
- WAIT_RISE: on rise, width_cnt <= 1 and go to HIGH.
- HIGH:
  - While s2 = 1: width_cnt increments each cycle, saturating at 2^CW − 1.
  - On fall: width_raw <= width_cnt, go to WAIT_RISE, and evaluate the pulse the next cycle.
  - Resulting width_raw equals the number of high samples, i.e. pulse width in ticks.
- Evaluate (cycle after fall):
  - If MIN_WIDTH ≤ width_raw ≤ MAX_WIDTH: position <= width_raw − OFFSET (low 8 bits), valid = 1, signal_lost <= 0.
  - Otherwise: pulse_err = 1, position holds, signal_lost unchanged.
  - valid and pulse_err are mutually exclusive and each lasts exactly 1 cycle.
- Latency: valid asserts 4 clk edges after the pwm_in falling transition (2 sync + detect + evaluate).
- Timeout counter:
  - Clears on every rise; otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: signal_lost <= 1.
  - If reached while in HIGH (stuck high): go to ARM; no valid or pulse_err is produced for that pulse.
- A rise on the same cycle the timeout would expire takes precedence: counter clears, signal_lost unchanged.
- Width counter saturation must not wrap. Any width above MAX_WIDTH yields pulse_err, never a small alias.
- rst asserted mid-pulse: all state returns to reset values next cycle, and decoding restarts via ARM.
- Glitch filtering beyond the synchroniser is out of scope. A 1-tick pulse measures width 1 and gives pulse_err.

Test Plan:
- Reset, then driver-equivalent pulses of 127 ticks high / 2502 period → valid once per period, position = 0, signal_lost falls after the first valid.
- Width 327 → position = 200. Width 382 → position = 255, valid, no pulse_err.
- Width 126, then width 383 → pulse_err each time, no valid, position holds its prior value (200), width_raw = 126 / 383.
- pwm_in held low 3000 cycles after a valid pulse → signal_lost = 1 exactly at timeout expiry. Next legal pulse → valid, signal_lost = 0.
- pwm_in high during reset release → first partial pulse ignored (no strobe); following full 227-tick pulse → position = 100.
- pwm_in stuck high 4000 cycles → signal_lost = 1, no valid/pulse_err. Line then low, then a 227-tick pulse → position = 100. rst asserted mid-pulse → outputs at reset values the following cycle.
